mem_access_unit: RTL and testbench



---
 rtl/mem_access_pkg.sv | 29 ++
 rtl/mem_access_unit_load_align_ext.sv | 34 +++
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the MEM-stage data-memory access path.
package mem_access_pkg;

  // Load-type encodings carried down the pipeline from decode
  localparam logic [2:0] LT_LB   = 3'b000;
  localparam logic [2:0] LT_LH   = 3'b001;
  localparam logic [2:0] LT_LW   = 3'b010;
  localparam logic [2:0] LT_LBU  = 3'b100;
  localparam logic [2:0] LT_LHU  = 3'b101;
  localparam logic [2:0] LT_NONE = 3'b111;

  // Store-width encodings taken from the instruction func3 field
  localparam logic [2:0] ST_SB = 3'b000;
  localparam logic [2:0] ST_SH = 3'b001;
  localparam logic [2:0] ST_SW = 3'b010;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_t;

  // Unlisted load-type codes behave like "no load"
  function automatic logic is_load_type(input logic [2:0] lt);
    return (lt == LT_LB) || (lt == LT_LH) || (lt == LT_LW) ||
           (lt == LT_LBU) || (lt == LT_LHU);
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align_ext.sv
// Byte/half lane select and sign/zero extension of a loaded memory word.
// Purely combinational so the MEM/WB forwarding path can reuse it.
module load_align_ext
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed lane, then extend according to the load type
  always_comb begin
    case (byte_off)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
    sel_half = byte_off[1] ? word[31:16] : word[15:0];
    case (load_type)
      LT_LB:   data = {{24{sel_byte[7]}}, sel_byte};
      LT_LBU:  data = {24'h000000, sel_byte};
      LT_LH:   data = {{16{sel_half[15]}}, sel_half};
      LT_LHU:  data = {16'h0000, sel_half};
      LT_LW:   data = word;
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: turns loads/stores from EX/MEM
// into a req/ack bus transaction, stalls the pipeline while it is in flight,
// and flags misaligned accesses and bus timeouts.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_result,
  input  logic [31:0] mem_op2_selected,
  input  logic        mem_memory_write,
  input  logic [2:0]  mem_memory_load_type,
  input  logic [2:0]  mem_func3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misaligned,
  output logic        bus_error
);

  localparam logic [1:0] IDLE = MEM_IDLE;
  localparam logic [1:0] REQ  = MEM_REQ;
  localparam logic [1:0] DONE = MEM_DONE;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [7:0]  wait_cnt;
  logic [2:0]  lat_load_type;
  logic [1:0]  lat_off;

  logic        load_req;
  logic        pending;
  logic        is_half;
  logic        is_word;
  logic        access_misaligned;
  logic [31:0] wdata_nxt;
  logic [3:0]  be_nxt;
  logic [31:0] ext_data;

  // Decode the instruction in MEM: pending access, width, alignment, lanes
  always_comb begin
    load_req = is_load_type(mem_memory_load_type);
    pending  = mem_memory_write | load_req;
    is_half  = 1'b0;
    is_word  = 1'b0;
    if (mem_memory_write) begin
      is_half = (mem_func3 == ST_SH);
      is_word = (mem_func3 != ST_SB) && (mem_func3 != ST_SH);
    end else if (load_req) begin
      is_half = (mem_memory_load_type == LT_LH) || (mem_memory_load_type == LT_LHU);
      is_word = (mem_memory_load_type == LT_LW);
    end
    access_misaligned = (is_half && mem_result[0]) ||
                        (is_word && (mem_result[1:0] != 2'b00));
    case (mem_func3)
      ST_SB: begin
        wdata_nxt = {4{mem_op2_selected[7:0]}};
        be_nxt    = 4'b0001 << mem_result[1:0];
      end
      ST_SH: begin
        wdata_nxt = {2{mem_op2_selected[15:0]}};
        be_nxt    = 4'b0011 << mem_result[1:0];
      end
      ST_SW: begin
        wdata_nxt = mem_op2_selected;
        be_nxt    = 4'b1111;
      end
      default: begin
        wdata_nxt = mem_op2_selected;
        be_nxt    = 4'b1111;
      end
    endcase
  end

  // Stall while a fresh aligned access is being launched or a request is in flight
  always_comb begin
    mem_stall = ~rst & (((state == IDLE) & pending & ~access_misaligned) |
                        (state == REQ));
  end

  load_align_ext u_load_align_ext (
    .word      (dmem_rdata),
    .byte_off  (lat_off),
    .load_type (lat_load_type),
    .data      (ext_data)
  );

  // Transaction FSM: launch from IDLE, wait for ack or timeout in REQ, release in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= 8'd0;
      lat_load_type <= LT_NONE;
      lat_off       <= 2'b00;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'h0;
      dmem_wdata    <= 32'h0;
      dmem_be       <= 4'h0;
      load_data     <= 32'h0;
      load_valid    <= 1'b0;
      misaligned    <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      misaligned <= 1'b0;
      bus_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            if (access_misaligned) begin
              misaligned <= 1'b1;
            end else begin
              dmem_req      <= 1'b1;
              dmem_we       <= mem_memory_write;
              dmem_addr     <= {mem_result[31:2], 2'b00};
              dmem_be       <= mem_memory_write ? be_nxt : 4'b1111;
              dmem_wdata    <= mem_memory_write ? wdata_nxt : 32'h0;
              lat_load_type <= mem_memory_write ? LT_NONE : mem_memory_load_type;
              lat_off       <= mem_result[1:0];
              wait_cnt      <= 8'd0;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_ack) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            load_data  <= ext_data;
            load_valid <= is_load_type(lat_load_type);
            state      <= DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            load_data  <= 32'h0;
            load_valid <= is_load_type(lat_load_type);
            bus_error  <= 1'b1;
            state      <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT_CYCLES = 4).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_result;
  logic [31:0] mem_op2_selected;
  logic        mem_memory_write;
  logic [2:0]  mem_memory_load_type;
  logic [2:0]  mem_func3;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misaligned;
  logic        bus_error;

  int checks = 0;
  int failures = 0;

  // Per-access observations gathered by runAccess
  int          obsStall;
  int          obsReq;
  int          obsValid;
  int          obsMis;
  int          obsErr;
  logic [31:0] obsLoad;
  logic [31:0] obsAddr;
  logic [31:0] obsWdata;
  logic [31:0] obsBe;
  logic [31:0] obsWe;
  logic        obsStable;
  logic        obsTimedOut;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .mem_result           (mem_result),
    .mem_op2_selected     (mem_op2_selected),
    .mem_memory_write     (mem_memory_write),
    .mem_memory_load_type (mem_memory_load_type),
    .mem_func3            (mem_func3),
    .dmem_req             (dmem_req),
    .dmem_we              (dmem_we),
    .dmem_addr            (dmem_addr),
    .dmem_wdata           (dmem_wdata),
    .dmem_be              (dmem_be),
    .dmem_ack             (dmem_ack),
    .dmem_rdata           (dmem_rdata),
    .mem_stall            (mem_stall),
    .load_data            (load_data),
    .load_valid           (load_valid),
    .misaligned           (misaligned),
    .bus_error            (bus_error)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic wr, input logic [2:0] lt, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data);
    mem_memory_write     = wr;
    mem_memory_load_type = lt;
    mem_func3            = f3;
    mem_result           = addr;
    mem_op2_selected     = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Present one instruction in MEM, hold it while stalled, answer the bus after
  // ackDelay extra REQ cycles (negative = never), and watch two cycles beyond.
  // Entered and left 1 time unit after a rising edge.
  task automatic runAccess(input logic wr, input logic [2:0] lt, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rdata, input int ackDelay);
    bit present = 1'b1;
    bit done = 1'b0;
    int post = 0;
    obsStall = 0; obsReq = 0; obsValid = 0; obsMis = 0; obsErr = 0;
    obsLoad = 32'h0; obsAddr = 32'h0; obsWdata = 32'h0; obsBe = 32'h0; obsWe = 32'h0;
    obsStable = 1'b1;
    obsTimedOut = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = rdata;
    applyStimulus(wr, lt, f3, addr, data);
    for (int i = 0; i < 60 && !done; i++) begin
      #1;
      if (mem_stall) obsStall++;
      if (load_valid) begin obsValid++; obsLoad = load_data; end
      if (bus_error) begin obsErr++; obsLoad = load_data; end
      if (misaligned) obsMis++;
      dmem_ack = 1'b0;
      if (dmem_req) begin
        if (obsReq == 0) begin
          obsAddr = dmem_addr; obsWdata = dmem_wdata;
          obsBe = {28'h0, dmem_be}; obsWe = {31'h0, dmem_we};
        end else if (obsAddr !== dmem_addr || obsWdata !== dmem_wdata ||
                     obsBe !== {28'h0, dmem_be} || obsWe !== {31'h0, dmem_we}) begin
          obsStable = 1'b0;
        end
        if (obsReq == ackDelay) dmem_ack = 1'b1;
        obsReq++;
      end
      if (!present) post++;
      if (present && !mem_stall) present = 1'b0;
      if (post >= 2) done = 1'b1;
      if (!done) begin
        @(posedge clk);
        #1;
        if (!present) applyStimulus(1'b0, 3'b111, 3'b000, 32'h0, 32'h0);
      end
    end
    if (!done) obsTimedOut = 1'b1;
    dmem_ack = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    applyStimulus(1'b0, 3'b111, 3'b000, 32'h0, 32'h0);

    // Reset values
    @(posedge clk); @(posedge clk); #2;
    checkOutput("rst_req", {31'h0, dmem_req}, 32'h0);
    checkOutput("rst_stall", {31'h0, mem_stall}, 32'h0);
    checkOutput("rst_addr", dmem_addr, 32'h0);
    checkOutput("rst_be", {28'h0, dmem_be}, 32'h0);
    checkOutput("rst_load_data", load_data, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // SW 0xDEADBEEF to 0x100, ack in first REQ cycle
    runAccess(1'b1, 3'b111, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    checkOutput("sw_bound", {31'h0, obsTimedOut}, 32'h0);
    checkOutput("sw_req_cycles", obsReq, 32'd1);
    checkOutput("sw_stall_cycles", obsStall, 32'd2);
    checkOutput("sw_be", obsBe, 32'hF);
    checkOutput("sw_addr", obsAddr, 32'h100);
    checkOutput("sw_wdata", obsWdata, 32'hDEADBEEF);
    checkOutput("sw_we", obsWe, 32'h1);
    checkOutput("sw_load_valid", obsValid, 32'd0);

    // SB 0xA5 to 0x103
    runAccess(1'b1, 3'b111, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0);
    checkOutput("sb_addr", obsAddr, 32'h100);
    checkOutput("sb_be", obsBe, 32'h8);
    checkOutput("sb_wdata", obsWdata, 32'hA5A5A5A5);

    // SH 0x1234BEEF to 0x102, one extra ack-wait cycle
    runAccess(1'b1, 3'b111, 3'b001, 32'h102, 32'h1234BEEF, 32'h0, 1);
    checkOutput("sh_be", obsBe, 32'hC);
    checkOutput("sh_wdata", obsWdata, 32'hBEEFBEEF);
    checkOutput("sh_req_cycles", obsReq, 32'd2);
    checkOutput("sh_stall_cycles", obsStall, 32'd3);
    checkOutput("sh_stable", {31'h0, obsStable}, 32'h1);

    // LB / LBU from 0x102, rdata 0x12F03456
    runAccess(1'b0, 3'b000, 3'b000, 32'h102, 32'h0, 32'h12F03456, 0);
    checkOutput("lb_data", obsLoad, 32'hFFFFFFF0);
    checkOutput("lb_valid_cycles", obsValid, 32'd1);
    checkOutput("lb_we", obsWe, 32'h0);
    checkOutput("lb_stall_cycles", obsStall, 32'd2);
    runAccess(1'b0, 3'b100, 3'b000, 32'h102, 32'h0, 32'h12F03456, 0);
    checkOutput("lbu_data", obsLoad, 32'h000000F0);

    // Half and word loads
    runAccess(1'b0, 3'b001, 3'b000, 32'h100, 32'h0, 32'h00008001, 0);
    checkOutput("lh_data", obsLoad, 32'hFFFF8001);
    runAccess(1'b0, 3'b101, 3'b000, 32'h102, 32'h0, 32'h80010000, 0);
    checkOutput("lhu_data", obsLoad, 32'h00008001);
    runAccess(1'b0, 3'b010, 3'b000, 32'h104, 32'h0, 32'hCAFEF00D, 0);
    checkOutput("lw_data", obsLoad, 32'hCAFEF00D);
    checkOutput("lw_addr", obsAddr, 32'h104);

    // Misaligned LH from 0x101 and SW to 0x102
    runAccess(1'b0, 3'b001, 3'b000, 32'h101, 32'h0, 32'h0, 0);
    checkOutput("lh_mis_pulse", obsMis, 32'd1);
    checkOutput("lh_mis_req", obsReq, 32'd0);
    checkOutput("lh_mis_stall", obsStall, 32'd0);
    runAccess(1'b1, 3'b111, 3'b010, 32'h102, 32'h55, 32'h0, 0);
    checkOutput("sw_mis_pulse", obsMis, 32'd1);
    checkOutput("sw_mis_req", obsReq, 32'd0);

    // Store and load both pending: the store wins
    runAccess(1'b1, 3'b010, 3'b010, 32'h108, 32'h11223344, 32'h55, 0);
    checkOutput("both_we", obsWe, 32'h1);
    checkOutput("both_wdata", obsWdata, 32'h11223344);
    checkOutput("both_valid", obsValid, 32'd0);

    // Non-memory instruction, including an unlisted load-type code
    runAccess(1'b0, 3'b011, 3'b000, 32'h100, 32'h0, 32'h0, 0);
    checkOutput("nop_stall", obsStall, 32'd0);
    checkOutput("nop_req", obsReq, 32'd0);
    checkOutput("nop_mis", obsMis, 32'd0);

    // LW timeout with ack never arriving
    runAccess(1'b0, 3'b010, 3'b000, 32'h10C, 32'h0, 32'hFFFFFFFF, -1);
    checkOutput("to_bound", {31'h0, obsTimedOut}, 32'h0);
    checkOutput("to_req_cycles", obsReq, 32'd4);
    checkOutput("to_bus_error", obsErr, 32'd1);
    checkOutput("to_load_data", obsLoad, 32'h0);
    checkOutput("to_stall_cycles", obsStall, 32'd5);

    // Reset during REQ
    applyStimulus(1'b0, 3'b010, 3'b000, 32'h200, 32'h0);
    dmem_rdata = 32'h0BADF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("mid_req_active", {31'h0, dmem_req}, 32'h1);
    rst = 1'b1;
    applyStimulus(1'b0, 3'b111, 3'b000, 32'h0, 32'h0);
    @(posedge clk); #2;
    checkOutput("mid_rst_req", {31'h0, dmem_req}, 32'h0);
    checkOutput("mid_rst_addr", dmem_addr, 32'h0);
    checkOutput("mid_rst_stall", {31'h0, mem_stall}, 32'h0);
    checkOutput("mid_rst_be", {28'h0, dmem_be}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // LW with ack delayed 3 cycles after reset
    runAccess(1'b0, 3'b010, 3'b000, 32'h200, 32'h0, 32'h13579BDF, 3);
    checkOutput("lw3_stall_cycles", obsStall, 32'd5);
    checkOutput("lw3_req_cycles", obsReq, 32'd4);
    checkOutput("lw3_data", obsLoad, 32'h13579BDF);
    checkOutput("lw3_stable", {31'h0, obsStable}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
